// File: rtl/inst_queue_pkg.sv
// Shared widths, the stored entry layout and small helpers for the fetch-to-decode instruction queue.
package inst_queue_pkg;
   localparam int unsigned INST_W      = 32;
   localparam int unsigned PC_W        = 32;
   localparam int unsigned FETCH_LANES = 2;
   localparam int unsigned ISSUE_LANES = 2;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } iq_entry_t;

   typedef enum logic [1:0] {
      FL_NONE,
      FL_ALL,
      FL_KEEP_DS
   } flush_e;

   function automatic logic [1:0] lane_count(input logic [1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction
endpackage

// File: rtl/inst_queue_iq_ram.sv
// Queue storage: two write ports for a compacted fetch pair, two async read ports for show-ahead issue.
module inst_queue_iq_ram
   import inst_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          i_we0,
   input  logic [AW-1:0] i_waddr0,
   input  iq_entry_t     i_wdata0,
   input  logic          i_we1,
   input  logic [AW-1:0] i_waddr1,
   input  iq_entry_t     i_wdata1,
   input  logic [AW-1:0] i_raddr0,
   input  logic [AW-1:0] i_raddr1,
   output iq_entry_t     o_rdata0,
   output iq_entry_t     o_rdata1
);
   iq_entry_t r_mem [DEPTH];

   // Write addresses are always tail and tail+1, so the two ports never collide.
   always_ff @(posedge clk) begin
      if (i_we0) r_mem[i_waddr0] <= i_wdata0;
      if (i_we1) r_mem[i_waddr1] <= i_wdata1;
   end

   assign o_rdata0 = r_mem[i_raddr0];
   assign o_rdata1 = r_mem[i_raddr1];
endmodule

// File: rtl/inst_queue.sv
// Circular instruction queue between 2-wide fetch and dual-issue decode: compaction, clipped pop,
// overflow drop, almost-full stall and flush that can preserve the branch delay-slot entry.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter  int unsigned DEPTH    = 16,
   parameter  int unsigned AF_SLACK = 4,
   localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          flush_keep_ds,
   input  logic [FETCH_LANES*INST_W-1:0] push_inst,
   input  logic [FETCH_LANES*PC_W-1:0]   push_pc,
   input  logic [FETCH_LANES-1:0]        push_valid,
   input  logic                          hold,
   input  logic [1:0]                    pop_cnt,
   output logic [ISSUE_LANES*INST_W-1:0] out_inst,
   output logic [ISSUE_LANES*PC_W-1:0]   out_pc,
   output logic [ISSUE_LANES-1:0]        out_valid,
   output logic [CNT_W-1:0]              count,
   output logic                          almost_full,
   output logic                          overflow_err
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW-1:0]    r_head, r_tail;
   logic [CNT_W-1:0] r_count;
   logic             r_ds_pending, r_overflow;

   logic [1:0]       w_pop_req, w_npop, w_npush_raw, w_npush, w_push_n;
   logic             w_fits, w_do_push, w_ovf;
   logic [AW-1:0]    w_ds_ptr;
   flush_e           w_flush;
   iq_entry_t        w_lane0, w_lane1, w_wdata0, w_rd0, w_rd1;

   always_comb begin
      w_pop_req   = pop_cnt[1] ? 2'd2 : pop_cnt;
      w_npop      = '0;
      if (!hold) w_npop = (r_count < CNT_W'(w_pop_req)) ? r_count[1:0] : w_pop_req;
      w_npush_raw = lane_count(push_valid);
      // A pending delay-slot refill admits only the oldest valid lane.
      w_npush     = (r_ds_pending && w_npush_raw != 2'd0) ? 2'd1 : w_npush_raw;
      w_fits      = (r_count + CNT_W'(w_npush)) <= CNT_W'(DEPTH);
      w_do_push   = (w_npush != 2'd0) && w_fits && !flush;
      w_ovf       = (w_npush != 2'd0) && !w_fits && !flush;
      w_push_n    = w_do_push ? w_npush : 2'd0;
      w_ds_ptr    = r_head + AW'(w_npop);
      w_flush     = !flush ? FL_NONE : (flush_keep_ds ? FL_KEEP_DS : FL_ALL);
      w_lane0     = '{pc: push_pc[PC_W-1:0],      inst: push_inst[INST_W-1:0]};
      w_lane1     = '{pc: push_pc[2*PC_W-1:PC_W], inst: push_inst[2*INST_W-1:INST_W]};
      w_wdata0    = push_valid[0] ? w_lane0 : w_lane1;
   end

   inst_queue_iq_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk      (clk),
      .i_we0    (w_do_push),
      .i_waddr0 (r_tail),
      .i_wdata0 (w_wdata0),
      .i_we1    (w_do_push && w_npush == 2'd2),
      .i_waddr1 (r_tail + AW'(1)),
      .i_wdata1 (w_lane1),
      .i_raddr0 (r_head),
      .i_raddr1 (r_head + AW'(1)),
      .o_rdata0 (w_rd0),
      .o_rdata1 (w_rd1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head       <= '0;
         r_tail       <= '0;
         r_count      <= '0;
         r_ds_pending <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         if (w_ovf) r_overflow <= 1'b1;
         case (w_flush)
            FL_ALL: begin
               r_head       <= '0;
               r_tail       <= '0;
               r_count      <= '0;
               r_ds_pending <= 1'b0;
            end
            FL_KEEP_DS: begin
               r_head <= w_ds_ptr;
               if (r_count > CNT_W'(w_npop)) begin
                  r_tail       <= w_ds_ptr + AW'(1);
                  r_count      <= CNT_W'(1);
                  r_ds_pending <= 1'b0;
               end else begin
                  r_tail       <= w_ds_ptr;
                  r_count      <= '0;
                  r_ds_pending <= 1'b1;
               end
            end
            default: begin
               r_head  <= r_head + AW'(w_npop);
               r_tail  <= r_tail + AW'(w_push_n);
               r_count <= r_count + CNT_W'(w_push_n) - CNT_W'(w_npop);
               if (w_do_push) r_ds_pending <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid    = {r_count >= CNT_W'(2), r_count != '0};
   assign out_pc       = {out_valid[1] ? w_rd1.pc   : '0, out_valid[0] ? w_rd0.pc   : '0};
   assign out_inst     = {out_valid[1] ? w_rd1.inst : '0, out_valid[0] ? w_rd0.inst : '0};
   assign count        = r_count;
   assign almost_full  = r_count >= CNT_W'(DEPTH - AF_SLACK);
   assign overflow_err = r_overflow;
endmodule

// File: tb/tb_inst_queue.sv
// Directed scoreboard bench for inst_queue: stimulus queues hand-computed expected state, a monitor checks it.
module tb_inst_queue;
   logic        clk = 1'b0;
   logic        rst, flush, flush_keep_ds, hold;
   logic [63:0] push_inst, push_pc, out_inst, out_pc;
   logic [1:0]  push_valid, pop_cnt, out_valid;
   logic [4:0]  count;
   logic        almost_full, overflow_err;

   typedef struct {
      string       name;
      int          cnt;
      logic [31:0] pc0;
      logic [31:0] pc1;
      logic        af;
      logic        ovf;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   inst_queue #(.DEPTH(16), .AF_SLACK(4)) dut (
      .clk(clk), .rst(rst), .flush(flush), .flush_keep_ds(flush_keep_ds),
      .push_inst(push_inst), .push_pc(push_pc), .push_valid(push_valid),
      .hold(hold), .pop_cnt(pop_cnt), .out_inst(out_inst), .out_pc(out_pc),
      .out_valid(out_valid), .count(count), .almost_full(almost_full),
      .overflow_err(overflow_err)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
      end
   endtask

   // Monitor: outputs depend only on registered state, so sampling at negedge is race-free.
   initial begin
      exp_t e;
      logic [1:0] v;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            v = {e.cnt >= 2, e.cnt >= 1};
            chk(e.name, "count", 32'(count), 32'(e.cnt));
            chk(e.name, "valid", 32'(out_valid), 32'(v));
            chk(e.name, "pc0", out_pc[31:0], e.pc0);
            chk(e.name, "pc1", out_pc[63:32], e.pc1);
            chk(e.name, "inst0", out_inst[31:0], v[0] ? inst_of(e.pc0) : 32'h0);
            chk(e.name, "inst1", out_inst[63:32], v[1] ? inst_of(e.pc1) : 32'h0);
            chk(e.name, "af", 32'(almost_full), 32'(e.af));
            chk(e.name, "ovf", 32'(overflow_err), 32'(e.ovf));
         end
      end
   end

   task automatic cyc(input logic [1:0] pv, input logic [31:0] p0, input logic [31:0] p1,
                      input logic [1:0] pc_n, input logic h, input logic fl, input logic k,
                      input string nm, input int ecnt, input logic [31:0] e0,
                      input logic [31:0] e1, input logic eaf, input logic eovf);
      exp_t e;
      push_valid    = pv;
      push_pc       = {p1, p0};
      push_inst     = {inst_of(p1), inst_of(p0)};
      pop_cnt       = pc_n;
      hold          = h;
      flush         = fl;
      flush_keep_ds = k;
      @(posedge clk);
      #1;
      e.name = nm; e.cnt = ecnt; e.pc0 = e0; e.pc1 = e1; e.af = eaf; e.ovf = eovf;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      rst = 1'b1; flush = 1'b0; flush_keep_ds = 1'b0; hold = 1'b0;
      push_valid = '0; push_pc = '0; push_inst = '0; pop_cnt = '0;
      repeat (2) @(posedge clk);
      #1;
      e.name = "reset"; e.cnt = 0; e.pc0 = 0; e.pc1 = 0; e.af = 0; e.ovf = 0;
      exp_q.push_back(e);
      @(negedge clk);
      rst = 1'b0;

      // Basic dual push, then drain.
      cyc(2'b11, 32'h100, 32'h104, 2'd0, 0, 0, 0, "push2", 2, 32'h100, 32'h104, 0, 0);
      cyc(2'b00, 32'h0, 32'h0, 2'd2, 0, 0, 0, "pop2", 0, 32'h0, 32'h0, 0, 0);

      // Lane1-only push; over-pop with simultaneous push; hold; pop_cnt=3 acts as 2.
      cyc(2'b10, 32'h0, 32'h300, 2'd0, 0, 0, 0, "lane1", 1, 32'h300, 32'h0, 0, 0);
      cyc(2'b10, 32'h0, 32'h200, 2'd2, 0, 0, 0, "overpop", 1, 32'h200, 32'h0, 0, 0);
      cyc(2'b00, 32'h0, 32'h0, 2'd2, 1, 0, 0, "hold", 1, 32'h200, 32'h0, 0, 0);
      cyc(2'b00, 32'h0, 32'h0, 2'd3, 0, 0, 0, "pop3", 0, 32'h0, 32'h0, 0, 0);

      // Single push/pop stream crossing the pointer wrap.
      for (int i = 0; i < 20; i++)
         cyc(2'b01, 32'h1000 + 32'(4*i), 32'h0, 2'd1, 0, 0, 0, "wrap", 1,
             32'h1000 + 32'(4*i), 32'h0, 0, 0);
      cyc(2'b00, 32'h0, 32'h0, 2'd1, 0, 0, 0, "wrapdrain", 0, 32'h0, 32'h0, 0, 0);

      // Fill to almost-full and beyond, then overflow drop.
      for (int i = 0; i < 6; i++)
         cyc(2'b11, 32'h2000 + 32'(8*i), 32'h2004 + 32'(8*i), 2'd0, 0, 0, 0, "fill",
             2*(i+1), 32'h2000, 32'h2004, (2*(i+1) >= 12), 0);
      cyc(2'b11, 32'h2060, 32'h2064, 2'd0, 0, 0, 0, "fill14", 14, 32'h2000, 32'h2004, 1, 0);
      cyc(2'b01, 32'h2070, 32'h0, 2'd0, 0, 0, 0, "fill15", 15, 32'h2000, 32'h2004, 1, 0);
      cyc(2'b11, 32'h3000, 32'h3004, 2'd0, 0, 0, 0, "drop", 15, 32'h2000, 32'h2004, 1, 1);
      cyc(2'b01, 32'h2080, 32'h0, 2'd0, 0, 0, 0, "full", 16, 32'h2000, 32'h2004, 1, 1);
      cyc(2'b01, 32'h3100, 32'h0, 2'd2, 0, 0, 0, "droppop", 14, 32'h2008, 32'h200C, 1, 1);

      // Plain flush, then flush keeping the delay slot.
      cyc(2'b00, 32'h0, 32'h0, 2'd0, 0, 1, 0, "flush", 0, 32'h0, 32'h0, 0, 1);
      cyc(2'b11, 32'h500, 32'h504, 2'd0, 0, 0, 0, "AB", 2, 32'h500, 32'h504, 0, 1);
      cyc(2'b01, 32'h508, 32'h0, 2'd0, 0, 0, 0, "C", 3, 32'h500, 32'h504, 0, 1);
      cyc(2'b11, 32'h900, 32'h904, 2'd1, 0, 1, 1, "keepds", 1, 32'h504, 32'h0, 0, 1);

      // Delay slot not yet fetched: next push keeps only its oldest lane.
      cyc(2'b00, 32'h0, 32'h0, 2'd1, 0, 1, 1, "keepempty", 0, 32'h0, 32'h0, 0, 1);
      cyc(2'b11, 32'h600, 32'h604, 2'd0, 0, 0, 0, "dsfill", 1, 32'h600, 32'h0, 0, 1);
      cyc(2'b10, 32'h0, 32'h700, 2'd0, 0, 0, 0, "dsclear", 2, 32'h600, 32'h700, 0, 1);

      // A plain flush cancels a pending delay-slot refill.
      cyc(2'b00, 32'h0, 32'h0, 2'd2, 0, 1, 1, "keepall", 0, 32'h0, 32'h0, 0, 1);
      cyc(2'b00, 32'h0, 32'h0, 2'd0, 0, 1, 0, "flushds", 0, 32'h0, 32'h0, 0, 1);
      cyc(2'b11, 32'h800, 32'h804, 2'd0, 0, 0, 0, "nods", 2, 32'h800, 32'h804, 0, 1);

      // Reset clears the sticky overflow and the queue.
      rst = 1'b1;
      cyc(2'b11, 32'hA00, 32'hA04, 2'd0, 0, 0, 0, "rst2", 0, 32'h0, 32'h0, 0, 0);
      rst = 1'b0;

      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d expected=0 pending", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
